// File: rtl/dma_burst_engine.sv
// dma_burst_engine: one-command-at-a-time AXI4 burst master that fills DMA_FIFO1 from
// read bursts and drains DMA_FIFO2 into write bursts.
module dma_burst_engine #(
    parameter int BITLEN   = 64,
    parameter int ADDR     = 32,
    parameter int RD_BEATS = 8,
    parameter int WR_BEATS = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR-1:0]   cmd_addr,
    output logic              ar_valid,
    input  logic              ar_ready,
    output logic [ADDR-1:0]   ar_addr,
    output logic [7:0]        ar_len,
    input  logic              r_valid,
    output logic              r_ready,
    input  logic [BITLEN-1:0] r_data,
    input  logic              r_last,
    output logic              aw_valid,
    input  logic              aw_ready,
    output logic [ADDR-1:0]   aw_addr,
    output logic [7:0]        aw_len,
    output logic              w_valid,
    input  logic              w_ready,
    output logic [BITLEN-1:0] w_data,
    output logic              w_last,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [1:0]        b_resp,
    output logic [BITLEN-1:0] DMA_FIFO1_din,
    output logic              DMA_FIFO1_wr_en,
    input  logic              DMA_FIFO1_full,
    input  logic [BITLEN-1:0] DMA_FIFO2_dout,
    output logic              DMA_FIFO2_rd_en,
    input  logic              DMA_FIFO2_empty,
    output logic              busy,
    output logic              done,
    output logic [2:0]        err
);
    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP} state_t;
    localparam int LSB = $clog2(BITLEN / 8);
    localparam logic [ADDR-1:0] AMASK = ~ADDR'((1 << LSB) - 1);
    localparam logic [8:0] RD_LAST = 9'(RD_BEATS - 1);
    localparam logic [8:0] WR_LAST = 9'(WR_BEATS - 1);
    state_t state_q, state_d;
    logic [8:0] cnt_q, cnt_d;
    logic [ADDR-1:0] addr_q, addr_d;
    logic [2:0] err_q, err_d;
    logic cmd_ready_q, ar_valid_q, aw_valid_q, b_ready_q, busy_q, done_q;
    logic r_hs, w_hs, b_hs, cmd_hs;
    assign r_ready = (state_q == RD_DATA) & ~DMA_FIFO1_full;
    assign r_hs = r_valid & r_ready;
    assign w_valid = (state_q == WR_DATA) & ~DMA_FIFO2_empty;
    assign w_hs = w_valid & w_ready;
    assign b_hs = b_valid & b_ready_q;
    assign cmd_hs = cmd_valid & cmd_ready_q;
    assign cmd_ready = cmd_ready_q;
    assign ar_valid = ar_valid_q;
    assign aw_valid = aw_valid_q;
    assign b_ready = b_ready_q;
    assign busy = busy_q;
    assign done = done_q;
    assign err = err_q;
    assign ar_addr = ar_valid_q ? addr_q : '0;
    assign aw_addr = aw_valid_q ? addr_q : '0;
    assign ar_len = 8'(RD_BEATS - 1);
    assign aw_len = 8'(WR_BEATS - 1);
    assign DMA_FIFO1_wr_en = r_hs;
    assign DMA_FIFO1_din = r_hs ? r_data : '0;
    assign DMA_FIFO2_rd_en = w_hs;
    // FWFT head only advances on a pop, so w_data stays stable through w_ready stalls
    assign w_data = w_valid ? DMA_FIFO2_dout : '0;
    assign w_last = (state_q == WR_DATA) & (cnt_q == WR_LAST);
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        addr_d = addr_q;
        err_d = err_q;
        case (state_q)
            IDLE: if (cmd_hs) begin
                addr_d = cmd_addr & AMASK;
                state_d = cmd_op == 2'b01 ? RD_ADDR : cmd_op == 2'b10 ? WR_ADDR : IDLE;
                err_d[0] = err_q[0] | (cmd_op == 2'b00) | (cmd_op == 2'b11);
            end
            RD_ADDR: if (ar_ready) state_d = RD_DATA;
            RD_DATA: if (r_hs) begin
                cnt_d = cnt_q + 9'd1;
                err_d[1] = err_q[1] | (r_last != (cnt_q == RD_LAST));
                state_d = cnt_q == RD_LAST ? IDLE : RD_DATA;
            end
            WR_ADDR: if (aw_ready) state_d = WR_DATA;
            WR_DATA: if (w_hs) begin
                cnt_d = cnt_q + 9'd1;
                state_d = cnt_q == WR_LAST ? WR_RESP : WR_DATA;
            end
            WR_RESP: if (b_hs) begin
                err_d[2] = err_q[2] | (b_resp != 2'b00);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        cnt_d = state_d != state_q ? 9'd0 : cnt_d;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q <= '0;
            addr_q <= '0;
            err_q <= '0;
            cmd_ready_q <= 1'b0;
            ar_valid_q <= 1'b0;
            aw_valid_q <= 1'b0;
            b_ready_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            addr_q <= addr_d;
            err_q <= err_d;
            cmd_ready_q <= state_d == IDLE;
            ar_valid_q <= state_d == RD_ADDR;
            aw_valid_q <= state_d == WR_ADDR;
            b_ready_q <= state_d == WR_RESP;
            busy_q <= state_d != IDLE;
            done_q <= (state_d == IDLE) & (state_q != IDLE);
        end
    end
endmodule

// File: tb/tb_dma_burst_engine.sv
// tb_dma_burst_engine: table-driven command bench with AXI slave and FIFO models
module tb_dma_burst_engine;
    logic clk = 1'b0, rst_n = 1'b0;
    logic cmd_valid, cmd_ready;
    logic [1:0] cmd_op;
    logic [31:0] cmd_addr;
    logic ar_valid, ar_ready, r_valid, r_ready, r_last;
    logic [31:0] ar_addr, aw_addr;
    logic [7:0] ar_len, aw_len;
    logic [63:0] r_data, w_data, DMA_FIFO1_din, DMA_FIFO2_dout;
    logic aw_valid, aw_ready, w_valid, w_ready, w_last, b_valid, b_ready;
    logic [1:0] b_resp;
    logic DMA_FIFO1_wr_en, DMA_FIFO1_full, DMA_FIFO2_rd_en, DMA_FIFO2_empty;
    logic busy, done;
    logic [2:0] err;
    int n_chk = 0, n_pass = 0;

    dma_burst_engine dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_len(ar_len),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_last(r_last),
        .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr), .aw_len(aw_len),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_last(w_last),
        .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp),
        .DMA_FIFO1_din(DMA_FIFO1_din), .DMA_FIFO1_wr_en(DMA_FIFO1_wr_en),
        .DMA_FIFO1_full(DMA_FIFO1_full),
        .DMA_FIFO2_dout(DMA_FIFO2_dout), .DMA_FIFO2_rd_en(DMA_FIFO2_rd_en),
        .DMA_FIFO2_empty(DMA_FIFO2_empty),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] addr;
        int          last_beat;
        int          stall_at;
        int          stall_len;
        logic [1:0]  bresp;
        bit          toggle;
        logic [31:0] exp_addr;
        logic [2:0]  exp_err;
    } vec_t;
    vec_t tbl[7];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [63:0] rdat(input logic [31:0] a, input int b);
        return {a, 32'(b) + 32'h5A00};
    endfunction

    task automatic run(input vec_t v);
        int beat, cyc, st, cnt;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = v.op; cmd_addr = v.addr;
        #1;
        chk("cmd_ready", cmd_ready, 1'b1);
        @(negedge clk);
        cmd_valid = 1'b0;
        #1;
        chk("ar_valid", ar_valid, v.op == 2'b01);
        chk("aw_valid", aw_valid, v.op == 2'b10);
        beat = 0; cyc = 0; st = 0; cnt = 0;
        if (v.op == 2'b01) begin
            chk("ar_addr", ar_addr, v.exp_addr);
            chk("ar_len", ar_len, 8'd7);
            while (beat < 8 && cyc < 100) begin
                @(negedge clk);
                DMA_FIFO1_full = beat == v.stall_at && st < v.stall_len;
                if (DMA_FIFO1_full) st++;
                r_valid = 1'b1; r_data = rdat(v.addr, beat); r_last = beat == v.last_beat;
                #1;
                chk("r_ready", r_ready, !DMA_FIFO1_full);
                chk("fifo1_wr_en", DMA_FIFO1_wr_en, !DMA_FIFO1_full);
                if (DMA_FIFO1_wr_en) begin
                    cnt++;
                    chk("fifo1_din", DMA_FIFO1_din, rdat(v.addr, beat));
                end
                chk("done_mid_read", done, 1'b0);
                if (!DMA_FIFO1_full) beat++;
                cyc++;
            end
            @(negedge clk);
            r_valid = 1'b0; r_last = 1'b0; DMA_FIFO1_full = 1'b0;
            #1;
            chk("fifo1_pushes", cnt, 8);
        end else if (v.op == 2'b10) begin
            chk("aw_addr", aw_addr, v.exp_addr);
            chk("aw_len", aw_len, 8'd15);
            while (beat < 16 && cyc < 200) begin
                @(negedge clk);
                DMA_FIFO2_empty = beat == v.stall_at && st < v.stall_len;
                if (DMA_FIFO2_empty) st++;
                DMA_FIFO2_dout = rdat(v.addr, beat);
                w_ready = !v.toggle || cyc % 2 == 0;
                #1;
                chk("w_valid", w_valid, !DMA_FIFO2_empty);
                chk("fifo2_rd_en", DMA_FIFO2_rd_en, !DMA_FIFO2_empty && w_ready);
                if (w_valid) begin
                    chk("w_data", w_data, rdat(v.addr, beat));
                    chk("w_last", w_last, beat == 15);
                end
                if (DMA_FIFO2_rd_en) cnt++;
                if (!DMA_FIFO2_empty && w_ready) beat++;
                cyc++;
            end
            @(negedge clk);
            w_ready = 1'b0; DMA_FIFO2_empty = 1'b1; b_valid = 1'b1; b_resp = v.bresp;
            #1;
            chk("b_ready", b_ready, 1'b1);
            chk("w_valid_in_resp", w_valid, 1'b0);
            chk("fifo2_pops", cnt, 16);
            chk("done_before_resp", done, 1'b0);
            @(negedge clk);
            b_valid = 1'b0; b_resp = 2'b00;
            #1;
        end
        chk("done", done, v.op == 2'b01 || v.op == 2'b10);
        chk("err", err, v.exp_err);
        chk("busy_end", busy, 1'b0);
        chk("cmd_ready_end", cmd_ready, 1'b1);
    endtask

    initial begin
        cmd_valid = 0; cmd_op = 0; cmd_addr = 0; ar_ready = 1; aw_ready = 1;
        r_valid = 0; r_data = 0; r_last = 0; w_ready = 0; b_valid = 0; b_resp = 0;
        DMA_FIFO1_full = 0; DMA_FIFO2_dout = 0; DMA_FIFO2_empty = 1;
        tbl[0] = '{2'b01, 32'h1000_0000, 7, 0, 0, 2'b00, 1'b0, 32'h1000_0000, 3'b000};
        tbl[1] = '{2'b01, 32'h1000_0105, 7, 3, 5, 2'b00, 1'b0, 32'h1000_0100, 3'b000};
        tbl[2] = '{2'b10, 32'h2000_0040, 15, 0, 0, 2'b00, 1'b1, 32'h2000_0040, 3'b000};
        tbl[3] = '{2'b10, 32'h2000_0047, 15, 5, 3, 2'b10, 1'b0, 32'h2000_0040, 3'b100};
        tbl[4] = '{2'b11, 32'h3000_0000, 7, 0, 0, 2'b00, 1'b0, 32'h0, 3'b101};
        tbl[5] = '{2'b01, 32'h3000_0010, 7, 0, 0, 2'b00, 1'b0, 32'h3000_0010, 3'b101};
        tbl[6] = '{2'b01, 32'h3000_0200, 3, 0, 0, 2'b00, 1'b0, 32'h3000_0200, 3'b111};
        #12;
        chk("reset_cmd_ready", cmd_ready, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_err", err, 3'b000);
        chk("reset_ar_valid", ar_valid, 1'b0);
        chk("reset_ar_len", ar_len, 8'd7);
        chk("reset_aw_len", aw_len, 8'd15);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("post_reset_cmd_ready", cmd_ready, 1'b1);
        foreach (tbl[i]) run(tbl[i]);
        // second read aborted by reset on beat 5
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_addr = 32'h4000_0000;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int b = 0; b < 5; b++) begin
            @(negedge clk);
            r_valid = 1'b1; r_data = rdat(32'h4000_0000, b); r_last = 1'b0;
            #1;
            chk("pre_reset_push", DMA_FIFO1_wr_en, 1'b1);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_wr_en", DMA_FIFO1_wr_en, 1'b0);
        chk("abort_r_ready", r_ready, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_err", err, 3'b000);
        chk("abort_cmd_ready", cmd_ready, 1'b0);
        chk("abort_done", done, 1'b0);
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("abort_hold_wr_en", DMA_FIFO1_wr_en, 1'b0);
        end
        r_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("recover_cmd_ready", cmd_ready, 1'b1);
        chk("recover_busy", busy, 1'b0);
        chk("recover_err", err, 3'b000);
        run(tbl[0]);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
